// File: rtl/vram_pixel_writer.sv
// Packs (x,y)-tagged 8-bit pixels into 36-bit ZBT words (four lanes per word) and
// queues them for writing on the free write slots granted by the arbiter.
module vram_pixel_writer #(
  parameter int   FIFO_DEPTH = 4,
  parameter logic BANK       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [7:0]  pix_data,
  input  logic        flush,
  input  logic        wr_slot,
  output logic        vram_we,
  output logic [18:0] vram_addr,
  output logic [35:0] vram_write_data,
  output logic [3:0]  vram_bwe,
  output logic        idle
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Word FIFO: storage is data only, pointers and count are control.
  logic [18:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [3:0]    fifo_mask [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          full;
  logic          empty;

  // Pack register holding the word currently being assembled.
  logic          pack_pending;
  logic [18:0]   pack_addr;
  logic [31:0]   pack_data;
  logic [3:0]    pack_mask;
  logic          flush_req;

  logic          accept;
  logic          pop;
  logic [1:0]    lane;
  logic [18:0]   in_addr;
  logic [31:0]   merge_data;
  logic [3:0]    merge_mask;
  logic [31:0]   solo_data;
  logic [3:0]    solo_mask;

  logic          push;
  logic [18:0]   push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_mask;
  logic          nxt_pending;
  logic [18:0]   nxt_addr;
  logic [31:0]   nxt_data;
  logic [3:0]    nxt_mask;
  logic          nxt_flush;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign pix_ready = !full;
  assign accept    = pix_valid && pix_ready;
  assign pop       = wr_slot && !empty;
  assign lane      = pix_x[1:0];
  assign in_addr   = {BANK, pix_y, pix_x[9:2]};

  always_comb begin
    merge_data                      = pack_data;
    merge_data[{lane, 3'b000} +: 8] = pix_data;
    merge_mask                      = pack_mask | (4'b0001 << lane);
    solo_data                       = '0;
    solo_data[{lane, 3'b000} +: 8]  = pix_data;
    solo_mask                       = 4'b0001 << lane;
  end

  // Next-state of the pack register and the single push per cycle.
  always_comb begin
    push        = 1'b0;
    push_addr   = pack_addr;
    push_data   = pack_data;
    push_mask   = pack_mask;
    nxt_pending = pack_pending;
    nxt_addr    = pack_addr;
    nxt_data    = pack_data;
    nxt_mask    = pack_mask;
    nxt_flush   = flush_req;

    if (accept) begin
      if (pack_pending && (in_addr != pack_addr)) begin
        // Close the old word; the new pixel starts a fresh pack that stays open.
        push        = 1'b1;
        nxt_pending = 1'b1;
        nxt_addr    = in_addr;
        nxt_data    = solo_data;
        nxt_mask    = solo_mask;
      end else if (lane == 2'd3) begin
        push        = 1'b1;
        push_addr   = in_addr;
        push_data   = merge_data;
        push_mask   = merge_mask;
        nxt_pending = 1'b0;
        nxt_addr    = in_addr;
        nxt_data    = '0;
        nxt_mask    = '0;
      end else begin
        nxt_pending = 1'b1;
        nxt_addr    = in_addr;
        nxt_data    = merge_data;
        nxt_mask    = merge_mask;
      end
    end else if (flush_req && !full) begin
      if (pack_pending) begin
        push        = 1'b1;
        nxt_pending = 1'b0;
        nxt_data    = '0;
        nxt_mask    = '0;
      end
      nxt_flush = 1'b0;
    end

    if (flush) begin
      nxt_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack_pending <= 1'b0;
      pack_addr    <= '0;
      pack_data    <= '0;
      pack_mask    <= '0;
      flush_req    <= 1'b0;
    end else begin
      pack_pending <= nxt_pending;
      pack_addr    <= nxt_addr;
      pack_data    <= nxt_data;
      pack_mask    <= nxt_mask;
      flush_req    <= nxt_flush;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_mask[wr_ptr] <= push_mask;
    end
  end

  // Write port shows the FIFO head; all zero while nothing is queued.
  always_comb begin
    vram_we         = pop;
    vram_addr       = '0;
    vram_write_data = '0;
    vram_bwe        = '0;
    if (!empty) begin
      vram_addr       = fifo_addr[rd_ptr];
      vram_write_data = {4'b0000, fifo_data[rd_ptr]};
      vram_bwe        = fifo_mask[rd_ptr];
    end
  end

  assign idle = empty && !pack_pending && !flush_req;

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Bench for vram_pixel_writer: expected VRAM writes are queued as stimulus is
// driven and compared in order by a monitor whenever vram_we is seen.
module tb_vram_pixel_writer;

  localparam int FD = 4;

  logic        clk;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  pix_data;
  logic        flush;
  logic        wr_slot;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [35:0] vram_write_data;
  logic [3:0]  vram_bwe;
  logic        idle;

  typedef struct {
    logic [18:0] a;
    logic [35:0] d;
    logic [3:0]  b;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  vram_pixel_writer #(.FIFO_DEPTH(FD), .BANK(1'b0)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .flush(flush),
    .wr_slot(wr_slot), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_write_data(vram_write_data), .vram_bwe(vram_bwe), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (vram_we) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h bwe=%b", vram_addr, vram_write_data, vram_bwe);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (vram_addr !== e.a || vram_write_data !== e.d || vram_bwe !== e.b) begin
          failures++;
          $display("FAIL write got addr=%h data=%h bwe=%b want addr=%h data=%h bwe=%b",
                   vram_addr, vram_write_data, vram_bwe, e.a, e.d, e.b);
        end
      end
    end
  end

  function automatic logic [18:0] waddr(input int y, input int wx);
    logic [9:0] yy;
    logic [7:0] xx;
    yy = 10'(y);
    xx = 8'(wx);
    return {1'b0, yy, xx};
  endfunction

  function automatic exp_t mk(input logic [18:0] a, input logic [35:0] d, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.d = d;
    e.b = b;
    return e;
  endfunction

  task automatic send_pix(input int x, input int y, input logic [7:0] d);
    int n;
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_data  = d;
    n = 0;
    while (!pix_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pix_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout x=%0d y=%0d pix_ready=%b want 1", x, y, pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    cycles(1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pix_valid = 1'b0; flush = 1'b0; wr_slot = 1'b1;
    pix_x = '0; pix_y = '0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", pix_ready); end
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b want=0", vram_we); end
    checks++; if (vram_addr !== 19'd0) begin failures++; $display("FAIL rst_addr got=%h want=0", vram_addr); end
    checks++; if (vram_write_data !== 36'd0) begin failures++; $display("FAIL rst_data got=%h want=0", vram_write_data); end
    checks++; if (vram_bwe !== 4'd0) begin failures++; $display("FAIL rst_bwe got=%b want=0", vram_bwe); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b want=1", idle); end
    reset = 1'b1;
    cycles(2);
    checks++; if (idle !== 1'b1 || vram_we !== 1'b0) begin
      failures++; $display("FAIL post_rst idle=%b we=%b want idle=1 we=0", idle, vram_we);
    end
    wr_slot = 1'b0;
  endtask

  task automatic test_full_word();
    sb.push_back(mk(waddr(5, 0), 36'h0_4433_2211, 4'b1111));
    send_pix(0, 5, 8'h11);
    send_pix(1, 5, 8'h22);
    send_pix(2, 5, 8'h33);
    send_pix(3, 5, 8'h44);
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL full_queued_idle got=%b want=0", idle); end
    wr_slot = 1'b1;
    drain(50);
    wr_slot = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL full_drain left=%0d want=0", sb.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL full_idle got=%b want=1", idle); end
  endtask

  task automatic test_partial_flush();
    wr_slot = 1'b1;
    sb.push_back(mk(19'd2, 36'h0_0000_BBAA, 4'b0011));
    sb.push_back(mk(19'd5, 36'h0_0000_00CC, 4'b0001));
    send_pix(8, 0, 8'hAA);
    send_pix(9, 0, 8'hBB);
    send_pix(20, 0, 8'hCC);
    cycles(5);
    checks++; if (sb.size() != 1) begin failures++; $display("FAIL partial_held left=%0d want=1", sb.size()); end
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL partial_idle got=%b want=0", idle); end
    pulse_flush();
    drain(50);
    wr_slot = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL flush_drain left=%0d want=0", sb.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b want=1", idle); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    wr_slot = 1'b0;
    for (int k = 0; k < FD + 1; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      sb.push_back(mk(waddr(7, k), {4'b0000, w}, 4'b1111));
    end
    for (int i = 0; i < 4*FD; i++) begin
      send_pix(i, 7, 8'(i));
    end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b want=0", pix_ready); end
    fork
      begin
        for (int i = 4*FD; i < 4*FD + 4; i++) begin
          send_pix(i, 7, 8'(i));
        end
      end
      begin
        cycles(5);
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b want=0", pix_ready); end
        wr_slot = 1'b1;
      end
    join
    drain(100);
    wr_slot = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_drain left=%0d want=0", sb.size()); end
    checks++; if (idle !== 1'b1 || pix_ready !== 1'b1) begin
      failures++; $display("FAIL bp_end idle=%b ready=%b want 1 1", idle, pix_ready);
    end
  endtask

  task automatic test_flush_collision();
    wr_slot = 1'b0;
    sb.push_back(mk(waddr(9, 0), 36'h0_0000_0001, 4'b0001));
    sb.push_back(mk(waddr(9, 1), 36'h0_0002_0000, 4'b0100));
    send_pix(0, 9, 8'h01);
    pix_valid = 1'b1; pix_x = 10'd6; pix_y = 10'd9; pix_data = 8'h02; flush = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; flush = 1'b0;
    cycles(3);
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL coll_idle got=%b want=0", idle); end
    wr_slot = 1'b1;
    drain(50);
    cycles(3);
    wr_slot = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL coll_drain left=%0d want=0", sb.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL coll_end_idle got=%b want=1", idle); end
  endtask

  task automatic test_reset_mid();
    wr_slot = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_pix(i, 1, 8'(8'h80 + i));
    end
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", idle); end
    reset   = 1'b0;
    wr_slot = 1'b1;
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%b want=1", idle); end
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b want=1", pix_ready); end
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%b want=0", vram_we); end
    cycles(2);
    reset = 1'b1;
    cycles(10);
    checks++; if (vram_we !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL mid_after we=%b idle=%b want 0 1", vram_we, idle);
    end
    wr_slot = 1'b0;
  endtask

  task automatic test_overwrite();
    wr_slot = 1'b1;
    sb.push_back(mk(waddr(2, 0), 36'h0_7700_6600, 4'b1010));
    send_pix(1, 2, 8'h55);
    send_pix(1, 2, 8'h66);
    send_pix(3, 2, 8'h77);
    drain(50);
    cycles(2);
    wr_slot = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovw_drain left=%0d want=0", sb.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL ovw_idle got=%b want=1", idle); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_flush();
    test_backpressure();
    test_flush_collision();
    test_reset_mid();
    test_overwrite();
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_pixel_writer.md
Name: vram_pixel_writer

Overview:
- Upstream stage of the ZBT video RAM display path. Accepts a stream of 8-bit pixels tagged with (x,y) screen coordinates.
- Packs up to four horizontally adjacent pixels into one 36-bit VRAM word, using the same lane layout the display reader unpacks.
- Buffers packed words in a small FIFO and issues one ZBT write on each free slot granted by the top-level arbiter.
- Address layout is {BANK, y[9:0], x[9:2]}.

Parameters:
- FIFO_DEPTH, 4, number of packed-word entries; power of two, at least 2.
- BANK, 1'b0, value driven on vram_addr[18], for frame-buffer selection.

Ports:
- clk  in  1  system clock (pixel clock domain of the display path)
- reset  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel present on pix_x/pix_y/pix_data
- pix_ready  out  1  block can accept a pixel this cycle
- pix_x  in  10  pixel column
- pix_y  in  10  pixel row
- pix_data  in  8  pixel value
- flush  in  1  one-cycle pulse: write out any partially packed word
- wr_slot  in  1  arbiter grant: the ZBT port is free for a write this cycle
- vram_we  out  1  write strobe to ZBT mux
- vram_addr  out  19  write word address
- vram_write_data  out  36  write data; bits 35:32 are always 0
- vram_bwe  out  4  active-high byte-lane enables for bytes 0..3; the top level inverts them for the ZBT pins
- idle  out  1  nothing pending, queued, or requested

Behaviour:
- Reset (asserted low, asynchronous):
  - FIFO is emptied, the pack register is cleared (pending=0, mask=0, data=0), and flush_req=0.
  - Outputs: pix_ready=1, vram_we=0, vram_addr=0, vram_write_data=0, vram_bwe=0, idle=1.
  - Deassertion takes effect on the next clk edge. A reset asserted mid-operation discards all queued and partial data; nothing is written.
- Lane mapping: lane = pix_x[1:0]. The pixel goes to pack bits [8*lane+7 : 8*lane] and sets mask[lane]. Word address = {BANK, pix_y, pix_x[9:2]}.
- Acceptance: a pixel is accepted when pix_valid && pix_ready. pix_ready = (fifo_count != FIFO_DEPTH), so every accept has room for one push.
- On accept, rules in priority order:
  - a) pending=1 and the incoming word address differs from the pack address: push the old pack {addr, data, mask}. Reload the pack with the new pixel only (other lanes 0, mask one-hot), pending=1. The new pack is not closed this cycle, even if lane=3.
  - b) Otherwise, merge the pixel into the pack and set pending=1. Rewriting a lane already set overwrites the byte; the mask is unchanged.
  - c) If case b applies and the lane is 3, push the merged word this cycle and clear the pack (pending=0, mask=0).
- At most one push per cycle.
- Flush:
  - A flush pulse sets flush_req.
  - When flush_req=1, no pixel is accepted in that cycle, and the FIFO is not full: if pending, push the pack and clear it. Clear flush_req in either case.
  - A pixel accept takes precedence over flush in the same cycle; flush_req stays set.
  - flush with pending=0 clears flush_req on the next eligible cycle and writes nothing.
- Write side (combinational from the FIFO head):
  - vram_we = wr_slot && !empty; the head is popped in the same cycle.
  - vram_addr, vram_write_data = {4'b0, head data}, and vram_bwe show the head entry while non-empty, and are 0 when empty.
  - wr_slot while empty: no effect.
- Push and pop in the same cycle are allowed; fifo_count is then unchanged. Full and empty flags derive from a (log2 FIFO_DEPTH)+1-bit count.
- idle = empty && !pending && !flush_req.
- Words enter the FIFO in acceptance order and are written in that same order.
- No pixel is dropped while pix_ready=1. The block never writes a lane whose mask bit is 0.

Test Plan:
- Reset, then accept x=0..3, y=5, data 0x11,0x22,0x33,0x44, then wr_slot=1 -> one write: vram_addr={0,10'd5,8'd0}, vram_write_data=36'h0_4433_2211, vram_bwe=4'b1111, idle=1 afterwards.
- Accept x=8,9 (y=0), then x=20 -> first write: addr 2, data 0x0000_BBAA, bwe 4'b0011. Pixel at x=20 stays pending until flush, then writes addr 5, bwe 4'b0001.
- Hold wr_slot=0 and stream 4*FIFO_DEPTH pixels -> pix_ready drops to 0 after FIFO_DEPTH words. Raise wr_slot -> ready reasserts after the first pop; all words are written in order.
- Flush asserted in the same cycle as an accepted pixel at a different address -> pixel handled first; flush_req is serviced the next cycle; total writes equal 2 with correct masks.
- Assert reset mid-stream with 2 words queued and a partial pack -> vram_we stays 0 with no further writes; idle=1 and pix_ready=1 immediately.
- Pixels at the same address, lane 1, twice (0x55 then 0x66), then lane 3 -> single write with byte1=0x66 and bwe 4'b1010.
